// File: rtl/seq_pkg.sv
// seq_pkg
//   Shared definitions for the sequencer and its task timer:
//   - 3-bit sequencer state encoding (IDLE .. AED_DETECT)
//   - counter widths REPEAT_W / LEN_W
//   - timer FSM state type tstate_t
//   - is_timed_state(): 1 for states whose duration the timer measures
package seq_pkg;

  localparam int REPEAT_W = 8;
  localparam int LEN_W    = 16;
  localparam int STATE_W  = 3;

  localparam logic [STATE_W-1:0] IDLE         = 3'd0;
  localparam logic [STATE_W-1:0] RST          = 3'd1;
  localparam logic [STATE_W-1:0] BACK_BIAS    = 3'd2;
  localparam logic [STATE_W-1:0] FLUSH        = 3'd3;
  localparam logic [STATE_W-1:0] EXPOSE_TIME  = 3'd4;
  localparam logic [STATE_W-1:0] READOUT      = 3'd5;
  localparam logic [STATE_W-1:0] PANEL_STABLE = 3'd6;
  localparam logic [STATE_W-1:0] AED_DETECT   = 3'd7;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_COUNT = 2'd1,
    T_DONE  = 2'd2
  } tstate_t;

  function automatic logic is_timed_state(input logic [STATE_W-1:0] s);
    return (s == RST) || (s == BACK_BIAS) || (s == FLUSH) ||
           (s == EXPOSE_TIME) || (s == READOUT);
  endfunction

endpackage

// File: rtl/seq_tick_prescaler.sv
// seq_tick_prescaler
//   Emits a 1-cycle tick on every TICK_DIV-th enabled cycle.
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous active-high reset
//     clear  in  restart the division (counter back to 0)
//     en     in  count this cycle
//     tick_o out high in the enabled cycle that completes a TICK_DIV period
//   tick_o is decoded from the registered count so the owner sees the wrap
//   in the same cycle the last prescaler count is consumed.
module seq_tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick_o
);

  // Keep at least one bit so TICK_DIV=1 (tick every enabled cycle) still elaborates.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick_o = en && (cnt_reg == LAST);

endmodule

// File: rtl/seq_task_timer.sv
// seq_task_timer
//   Times each timed sequencer task (repeat x length x TICK_DIV cycles) and
//   hands task_done_o back to the sequencer.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     current_state_i     sequencer state (seq_pkg encoding)
//     repeat_count_i      repeats per task, 0 behaves as 1
//     data_length_i       ticks per repeat
//     task_done_o         task finished; held while the state is unchanged
//     active_o            timer is counting
//     abort_o             1-cycle pulse when a task is left before completion
//     rep_idx_o/len_idx_o progress indices, 0 while not counting
//     timeout_o           watchdog flag
//   Optional feature: define SEQ_TIMER_WATCHDOG_EN to add a watchdog on the
//   externally terminated states (PANEL_STABLE, AED_DETECT); otherwise
//   timeout_o is tied 0.
module seq_task_timer
  import seq_pkg::*;
#(
  parameter int TICK_DIV   = 100,
  parameter int WDOG_LIMIT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STATE_W-1:0]  current_state_i,
  input  logic [REPEAT_W-1:0] repeat_count_i,
  input  logic [LEN_W-1:0]    data_length_i,
  output logic                task_done_o,
  output logic                active_o,
  output logic                abort_o,
  output logic [REPEAT_W-1:0] rep_idx_o,
  output logic [LEN_W-1:0]    len_idx_o,
  output logic                timeout_o
);

  tstate_t             tstate_reg;
  logic [STATE_W-1:0]  lat_state_reg;
  logic [REPEAT_W-1:0] reps_reg;
  logic [REPEAT_W-1:0] rep_idx_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    len_idx_reg;
  logic                abort_reg;
  logic                state_match;
  logic                tick;

  assign state_match = (current_state_i == lat_state_reg);

  // The prescaler only runs while a task is being counted and is held at 0
  // otherwise, so every task starts on a fresh TICK_DIV period.
  seq_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (tstate_reg != T_COUNT),
    .en    ((tstate_reg == T_COUNT) && state_match),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tstate_reg    <= T_IDLE;
      lat_state_reg <= IDLE;
      reps_reg      <= '0;
      rep_idx_reg   <= '0;
      len_reg       <= '0;
      len_idx_reg   <= '0;
      abort_reg     <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (tstate_reg)
        T_IDLE: begin
          if (is_timed_state(current_state_i)) begin
            lat_state_reg <= current_state_i;
            reps_reg      <= (repeat_count_i == '0) ? REPEAT_W'(1) : repeat_count_i;
            len_reg       <= data_length_i;
            rep_idx_reg   <= '0;
            len_idx_reg   <= '0;
            tstate_reg    <= (data_length_i == '0) ? T_DONE : T_COUNT;
          end
        end
        T_COUNT: begin
          // Leaving the state takes priority over a wrap in the same cycle.
          if (!state_match) begin
            tstate_reg  <= T_IDLE;
            abort_reg   <= 1'b1;
            rep_idx_reg <= '0;
            len_idx_reg <= '0;
          end else if (tick) begin
            if (len_idx_reg == len_reg - LEN_W'(1)) begin
              len_idx_reg <= '0;
              if (rep_idx_reg == reps_reg - REPEAT_W'(1)) begin
                rep_idx_reg <= '0;
                tstate_reg  <= T_DONE;
              end else begin
                rep_idx_reg <= rep_idx_reg + REPEAT_W'(1);
              end
            end else begin
              len_idx_reg <= len_idx_reg + LEN_W'(1);
            end
          end
        end
        T_DONE: begin
          if (!state_match) begin
            tstate_reg <= T_IDLE;
          end
        end
        default: tstate_reg <= T_IDLE;
      endcase
    end
  end

  // Gated by the live state so done drops in the very cycle the sequencer moves on.
  assign task_done_o = (tstate_reg == T_DONE) && state_match;
  assign active_o    = (tstate_reg == T_COUNT);
  assign abort_o     = abort_reg;
  assign rep_idx_o   = rep_idx_reg;
  assign len_idx_o   = len_idx_reg;

`ifdef SEQ_TIMER_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_LIMIT);

  logic [STATE_W-1:0] prev_state_reg;
  logic [15:0]        wdog_cnt_reg;
  logic [15:0]        wdog_cnt_next;
  logic               watched;

  // The count equals the number of cycles already spent in the watched state;
  // entering a new state restarts it at 1 for the cycle being left behind.
  always_comb begin
    watched       = (current_state_i == PANEL_STABLE) || (current_state_i == AED_DETECT);
    wdog_cnt_next = '0;
    if (watched) begin
      if (current_state_i != prev_state_reg) begin
        wdog_cnt_next = 16'd1;
      end else if (wdog_cnt_reg != 16'hFFFF) begin
        wdog_cnt_next = wdog_cnt_reg + 16'd1;
      end else begin
        wdog_cnt_next = wdog_cnt_reg;
      end
    end
  end

  logic timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state_reg <= IDLE;
      wdog_cnt_reg   <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      prev_state_reg <= current_state_i;
      wdog_cnt_reg   <= wdog_cnt_next;
      timeout_reg    <= watched && (wdog_cnt_next >= WDOG_LIM);
    end
  end

  assign timeout_o = timeout_reg;
`else
  // WDOG_LIMIT only matters when the watchdog is built in.
  logic unused_wdog_limit;
  assign unused_wdog_limit = (WDOG_LIMIT != 0);
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_seq_task_timer.sv
module tb_seq_task_timer;
  import seq_pkg::*;

  localparam int TD = 4;
  localparam int WL = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  current_state_i;
  logic [7:0]  repeat_count_i;
  logic [15:0] data_length_i;
  logic        task_done_o;
  logic        active_o;
  logic        abort_o;
  logic [7:0]  rep_idx_o;
  logic [15:0] len_idx_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  seq_task_timer #(
    .TICK_DIV  (TD),
    .WDOG_LIMIT(WL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .current_state_i(current_state_i),
    .repeat_count_i (repeat_count_i),
    .data_length_i  (data_length_i),
    .task_done_o    (task_done_o),
    .active_o       (active_o),
    .abort_o        (abort_o),
    .rep_idx_o      (rep_idx_o),
    .len_idx_o      (len_idx_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  // Reference model: expected {done,active,abort,rep_idx,len_idx,timeout} in
  // cycle n of a task where state st is presented for cycles 0..hold-1 and
  // IDLE afterwards. Derived from the timing rules: counting occupies cycles
  // 1..K with K = max(rep,1)*len*TD, done is shown from cycle K+1.
  function automatic logic [27:0] model_out(input logic [2:0] st, input int n,
                                            input int hold, input int rep_in,
                                            input int len);
    int  reps, k, t, ri, li;
    bit  timed, watched, done, act, ab, to;
    reps    = (rep_in == 0) ? 1 : rep_in;
    k       = reps * len * TD;
    timed   = (st == RST) || (st == BACK_BIAS) || (st == FLUSH) ||
              (st == EXPOSE_TIME) || (st == READOUT);
    watched = (st == PANEL_STABLE) || (st == AED_DETECT);
    done = 0; act = 0; ab = 0; to = 0; ri = 0; li = 0;
    if (n <= hold) begin
      act  = timed && (len > 0) && (n >= 1) && (n <= k);
      done = timed && (n < hold) && (n >= k + 1);
    end
    if (n == hold + 1)
      ab = timed && (len > 0) && (hold >= 1) && (hold <= k);
    if (act) begin
      t  = (n - 1) / TD;
      ri = t / len;
      li = t % len;
    end
`ifdef SEQ_TIMER_WATCHDOG_EN
    to = watched && (n >= WL) && (n <= hold);
`else
    to = 0;
`endif
    return {done, act, ab, 8'(ri), 16'(li), to};
  endfunction

  function automatic logic [27:0] observed();
    return {task_done_o, active_o, abort_o, rep_idx_o, len_idx_o, timeout_o};
  endfunction

  task automatic test_reset();
    logic [27:0] got;
    reset = 1'b1;
    current_state_i = IDLE;
    repeat_count_i = 8'd0;
    data_length_i = 16'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      current_state_i = (i < 3) ? FLUSH : IDLE;
      repeat_count_i = 8'($urandom);
      data_length_i = 16'($urandom);
      if (i == 3) reset = 1'b0;
      @(negedge clk);
      got = observed();
      n_checks++;
      if (got !== 28'd0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: outputs got %h want 0000000", i, got);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_directed();
    logic [27:0] got, exp;
    int st[5], rp[5], ln[5], hd[5];
    st = '{FLUSH, BACK_BIAS, READOUT, EXPOSE_TIME, PANEL_STABLE};
    rp = '{2, 1, 0, 1, 1};
    ln = '{3, 0, 5, 10, 0};
    hd = '{30, 5, 25, 7, 60};
    for (int c = 0; c < 5; c++) begin
      for (int n = 0; n <= hd[c] + 2; n++) begin
        current_state_i = (n < hd[c]) ? 3'(st[c]) : IDLE;
        repeat_count_i = (n == 0) ? 8'(rp[c]) : 8'($urandom);
        data_length_i = (n == 0) ? 16'(ln[c]) : 16'($urandom_range(0, 3));
        @(negedge clk);
        got = observed();
        exp = model_out(3'(st[c]), n, hd[c], rp[c], ln[c]);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL directed case %0d cycle %0d: {done,act,abort,rep,len,to} got %h want %h",
                   c + 1, n, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_task();
    logic [27:0] got, exp;
    int hold2;
    hold2 = 8 * TD + 4;
    for (int n = 0; n <= 10; n++) begin
      current_state_i = FLUSH;
      repeat_count_i = (n == 0) ? 8'd1 : 8'($urandom);
      data_length_i = (n == 0) ? 16'd8 : 16'($urandom);
      reset = (n == 10);
      @(negedge clk);
      got = observed();
      exp = model_out(FLUSH, n, 1000, 1, 8);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid pre cycle %0d: got %h want %h", n, got, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int n = 0; n <= hold2 + 2; n++) begin
      current_state_i = (n < hold2) ? FLUSH : IDLE;
      repeat_count_i = (n == 0) ? 8'd1 : 8'($urandom);
      data_length_i = (n == 0) ? 16'd8 : 16'($urandom);
      @(negedge clk);
      got = observed();
      exp = model_out(FLUSH, n, hold2, 1, 8);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid post cycle %0d (abs %0d): got %h want %h", n, n + 11, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] got, exp;
    int hold, last;
    hold = 2 * TD + 2;
    for (int it = 0; it < 3; it++) begin
      last = (it == 2) ? hold + 2 : hold;
      for (int n = 0; n <= last; n++) begin
        current_state_i = (n < hold) ? FLUSH : IDLE;
        repeat_count_i = (n == 0) ? 8'd1 : 8'($urandom);
        data_length_i = (n == 0) ? 16'd2 : 16'($urandom);
        @(negedge clk);
        got = observed();
        exp = model_out(FLUSH, n, hold, 1, 2);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL back_to_back task %0d cycle %0d: got %h want %h", it, n, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [27:0] got, exp;
    logic [2:0]  st;
    int rp, ln, k, hold;
    bit timed;
    for (int it = 0; it < 30; it++) begin
      st = 3'($urandom_range(1, 7));
      rp = $urandom_range(0, 3);
      ln = $urandom_range(0, 6);
      timed = (st != PANEL_STABLE) && (st != AED_DETECT);
      k = ((rp == 0) ? 1 : rp) * ln * TD;
      if (timed && ln > 0 && $urandom_range(0, 2) == 0)
        hold = $urandom_range(1, k);
      else
        hold = k + 1 + $urandom_range(0, 3);
      for (int n = 0; n <= hold + 2; n++) begin
        current_state_i = (n < hold) ? st : IDLE;
        repeat_count_i = (n == 0) ? 8'(rp) : 8'($urandom);
        data_length_i = (n == 0) ? 16'(ln) : 16'($urandom);
        @(negedge clk);
        got = observed();
        exp = model_out(st, n, hold, rp, ln);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random task %0d st=%0d rep=%0d len=%0d hold=%0d cycle %0d: got %h want %h",
                   it, st, rp, ln, hold, n, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_task();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
